// File: rtl/fcmp_pkg.sv
// Shared field widths and operand-class types for the binary32 compare unit.
package fcmp_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned FRAC_W = 23;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  // Field view of a binary32 word, MSB first.
  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Per-operand classification flags.
  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic is_qnan;
    logic is_inf;
    logic is_zero;
  } fp_class_t;

endpackage

// File: rtl/fcmp_classify.sv
// Combinational classifier for one binary32 operand: NaN (signalling/quiet),
// infinity and zero. The sign is irrelevant to classification.
module fcmp_classify
  import fcmp_pkg::*;
(
  input  logic [EXP_W-1:0]  exp_i,
  input  logic [FRAC_W-1:0] frac_i,
  output fp_class_t         cls_o
);

  logic exp_max;
  logic frac_nz;

  assign exp_max = (exp_i == EXP_MAX);
  assign frac_nz = |frac_i;

  // Decode the operand class from exponent and fraction.
  always_comb begin
    cls_o         = '0;
    cls_o.is_nan  = exp_max & frac_nz;
    cls_o.is_qnan = exp_max & frac_i[FRAC_W-1];
    cls_o.is_snan = exp_max & frac_nz & ~frac_i[FRAC_W-1];
    cls_o.is_inf  = exp_max & ~frac_nz;
    cls_o.is_zero = (exp_i == '0) & ~frac_nz;
  end

endmodule

// File: rtl/fcmp_sp.sv
// Single-precision compare unit with one-cycle registered results.
// Optional NaN class outputs (snan/qnan) are built when FCMP_NAN_CLASS_EN
// is defined; otherwise those ports and their logic are absent.
module fcmp_sp
  import fcmp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        out_valid,
  output logic        unordered,
  output logic        altb,
  output logic        blta,
  output logic        aeqb,
  output logic        inf,
  output logic        zero
`ifdef FCMP_NAN_CLASS_EN
  ,
  output logic        snan,
  output logic        qnan
`endif
);

  fp32_t     a_fp;
  fp32_t     b_fp;
  fp_class_t cls_a;
  fp_class_t cls_b;
  logic [EXP_W+FRAC_W-1:0] mag_a;
  logic [EXP_W+FRAC_W-1:0] mag_b;

  assign a_fp  = opa;
  assign b_fp  = opb;
  assign mag_a = {a_fp.exp, a_fp.frac};
  assign mag_b = {b_fp.exp, b_fp.frac};

  fcmp_classify u_cls_a (.exp_i(a_fp.exp), .frac_i(a_fp.frac), .cls_o(cls_a));
  fcmp_classify u_cls_b (.exp_i(b_fp.exp), .frac_i(b_fp.frac), .cls_o(cls_b));

  logic out_valid_q;
  logic unordered_d, unordered_q;
  logic altb_d, altb_q;
  logic blta_d, blta_q;
  logic aeqb_d, aeqb_q;
  logic inf_d, inf_q;
  logic zero_d, zero_q;

  // Ordering: NaN suppresses all relations, +0/-0 are equal, differing signs
  // decide directly, equal signs compare magnitude (reversed when negative).
  always_comb begin
    unordered_d = cls_a.is_nan | cls_b.is_nan;
    altb_d      = 1'b0;
    blta_d      = 1'b0;
    aeqb_d      = 1'b0;
    if (!unordered_d) begin
      if (cls_a.is_zero && cls_b.is_zero) begin
        aeqb_d = 1'b1;
      end else if (a_fp.sign != b_fp.sign) begin
        altb_d = a_fp.sign;
        blta_d = b_fp.sign;
      end else if (mag_a == mag_b) begin
        aeqb_d = 1'b1;
      end else if ((mag_a < mag_b) ^ a_fp.sign) begin
        altb_d = 1'b1;
      end else begin
        blta_d = 1'b1;
      end
    end
    inf_d  = cls_a.is_inf | cls_b.is_inf;
    zero_d = cls_a.is_zero;
  end

  // Result registers: load on in_valid, hold otherwise; reset clears all.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      unordered_q <= 1'b0;
      altb_q      <= 1'b0;
      blta_q      <= 1'b0;
      aeqb_q      <= 1'b0;
      inf_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        unordered_q <= unordered_d;
        altb_q      <= altb_d;
        blta_q      <= blta_d;
        aeqb_q      <= aeqb_d;
        inf_q       <= inf_d;
        zero_q      <= zero_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign unordered = unordered_q;
  assign altb      = altb_q;
  assign blta      = blta_q;
  assign aeqb      = aeqb_q;
  assign inf       = inf_q;
  assign zero      = zero_q;

`ifdef FCMP_NAN_CLASS_EN
  logic snan_d, snan_q;
  logic qnan_d, qnan_q;

  assign snan_d = cls_a.is_snan | cls_b.is_snan;
  assign qnan_d = cls_a.is_qnan | cls_b.is_qnan;

  // NaN class registers share the load/hold/reset behaviour of the results.
  always_ff @(posedge clk) begin
    if (rst) begin
      snan_q <= 1'b0;
      qnan_q <= 1'b0;
    end else if (in_valid) begin
      snan_q <= snan_d;
      qnan_q <= qnan_d;
    end
  end

  assign snan = snan_q;
  assign qnan = qnan_q;
`else
  // NaN sub-class flags are not consumed in this build.
  logic unused_nan_class;
  assign unused_nan_class = &{1'b0, cls_a.is_snan, cls_a.is_qnan,
                              cls_b.is_snan, cls_b.is_qnan};
`endif

endmodule

// File: tb/tb_fcmp_sp.sv
// Self-checking bench for fcmp_sp: directed vectors followed by randomized
// operands, compared against an ordering model based on signed keys.
module tb_fcmp_sp;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        out_valid;
  logic        unordered;
  logic        altb;
  logic        blta;
  logic        aeqb;
  logic        inf;
  logic        zero;
`ifdef FCMP_NAN_CLASS_EN
  logic        snan;
  logic        qnan;
`endif

  int checks = 0;
  int errors = 0;

  // Held expected flags {unordered,altb,blta,aeqb,inf,zero,snan,qnan}.
  logic [7:0] held;

  fcmp_sp dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .opa       (opa),
    .opb       (opb),
    .out_valid (out_valid),
    .unordered (unordered),
    .altb      (altb),
    .blta      (blta),
    .aeqb      (aeqb),
    .inf       (inf),
    .zero      (zero)
`ifdef FCMP_NAN_CLASS_EN
    ,
    .snan      (snan),
    .qnan      (qnan)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b (v,unord,altb,blta,aeqb,inf,zero,snan,qnan)",
               tag, got, want);
    end
  endtask

  function automatic bit is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  // Map a non-NaN binary32 onto a signed integer whose order is the real order;
  // both zeros map to 0.
  function automatic longint key(input logic [31:0] x);
    longint m;
    m = longint'(x[30:0]);
    return x[31] ? -m : m;
  endfunction

  function automatic logic [7:0] model(input logic [31:0] a, input logic [31:0] b);
    logic un, lt, gt, eq, fin, fz, fs, fq;
    un = is_nan(a) || is_nan(b);
    lt = 1'b0; gt = 1'b0; eq = 1'b0;
    if (!un) begin
      lt = key(a) <  key(b);
      gt = key(a) >  key(b);
      eq = key(a) == key(b);
    end
    fin = (a[30:0] == 31'h7F800000) || (b[30:0] == 31'h7F800000);
    fz  = (a[30:0] == 0);
`ifdef FCMP_NAN_CLASS_EN
    fs = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
    fq = (a[30:23] == 8'hFF && a[22]) || (b[30:23] == 8'hFF && b[22]);
`else
    fs = 1'b0;
    fq = 1'b0;
`endif
    return {un, lt, gt, eq, fin, fz, fs, fq};
  endfunction

  function automatic logic [8:0] observed();
    logic s, q;
`ifdef FCMP_NAN_CLASS_EN
    s = snan;
    q = qnan;
`else
    s = 1'b0;
    q = 1'b0;
`endif
    return {out_valid, unordered, altb, blta, aeqb, inf, zero, s, q};
  endfunction

  // One clock: drive inputs, advance, then compare against the model.
  task automatic step(input logic r, input logic v, input logic [31:0] a,
                      input logic [31:0] b, input string tag);
    logic exp_v;
    rst = r; in_valid = v; opa = a; opb = b;
    @(posedge clk);
    #1;
    if (r) begin
      exp_v = 1'b0;
      held  = '0;
    end else begin
      exp_v = v;
      if (v) held = model(a, b);
    end
    $display("txn %s rst=%0b v=%0b a=%08h b=%08h -> %b", tag, r, v, a, b, observed());
    check(tag, observed(), {exp_v, held});
  endtask

  function automatic logic [31:0] pick(input logic [31:0] other);
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0: return {r[31], 31'h0};
      1: return {r[31], 31'h7F800000};
      2: return {r[31], 8'hFF, 1'b1, r[21:0]};
      3: return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
      4: return {r[31], 8'h00, 15'h0, r[7:0]};
      5: return other;
      6: return {~other[31], other[30:0]};
      7: return other + {31'h0, r[0]} - {31'h0, r[1]};
      default: return r;
    endcase
  endfunction

  initial begin
    held = '0;
    rst = 1'b1; in_valid = 1'b0; opa = '0; opb = '0;
    step(1'b1, 1'b0, 32'h0, 32'h0, "reset0");
    step(1'b1, 1'b1, 32'h3F800000, 32'h40000000, "reset_wins");

    step(1'b0, 1'b1, 32'h3F800000, 32'h40000000, "one_lt_two");
    step(1'b0, 1'b1, 32'h00000000, 32'h80000000, "pz_nz");
    step(1'b0, 1'b1, 32'h80000000, 32'h00000000, "nz_pz");
    step(1'b0, 1'b1, 32'hBF800000, 32'hC0000000, "neg_order");
    step(1'b0, 1'b1, 32'h00000001, 32'h00000002, "denorm");
    step(1'b0, 1'b1, 32'h7FC00000, 32'h3F800000, "qnan_a");
    step(1'b0, 1'b1, 32'h7F800001, 32'h3F800000, "snan_a");
    step(1'b0, 1'b1, 32'h7F800000, 32'hFF800000, "inf_pair");
    step(1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0, "hold");
    step(1'b0, 1'b1, 32'h80000001, 32'h00000000, "negden_zero");
    step(1'b0, 1'b1, 32'h41200000, 32'h41200000, "equal");

    // Back-to-back stream with reset on the third edge.
    step(1'b0, 1'b1, 32'h40400000, 32'h40000000, "strm1");
    step(1'b0, 1'b1, 32'hC0400000, 32'h40000000, "strm2");
    step(1'b1, 1'b1, 32'h7FC00000, 32'h7F800000, "strm3_rst");
    step(1'b0, 1'b1, 32'h00000000, 32'hFF800000, "strm4");

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = pick($urandom);
      b = pick(a);
      if ($urandom_range(0, 1)) begin
        logic [31:0] t;
        t = a; a = b; b = t;
      end
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) != 0), a, b, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
